calc_key_seq: RTL and testbench
===============================

Name: calc_key_seq

Overview:
Operand-entry sequencer directly upstream of the 6-bit add/sub unit in the calc datapath. Accepts one key event per pulse (hex digit, +, -, =, clear) and builds operands A and B by hex-digit shifting. It drives a, b and sub_sel into the add/sub unit and latches that unit's combinational result on '='. It also supports chained operations (result becomes next A) and a display register for the downstream display stage.

Parameters:
WIDTH, 6, operand/result width; must match the add/sub unit
DIGIT_W, 4, bits per entered digit (hex keypad)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  5  0-15 hex digit; 16 PLUS; 17 MINUS; 18 EQUAL; 19 CLEAR; 20-31 ignored
result  in  WIDTH  combinational sum/difference from the add/sub unit
a  out  WIDTH  operand A to the add/sub unit
b  out  WIDTH  operand B to the add/sub unit
sub_sel  out  1  0 = a+b, 1 = a-b
disp  out  WIDTH  value for the display stage
res_valid  out  1  one-cycle pulse, disp holds a fresh result
state  out  2  current FSM state, for debug/LEDs

Behaviour:
- Reset (async, any time, including mid-entry): a=0, b=0, sub_sel=0, disp=0, res_valid=0, state=ENTER_A. CLEAR key has the same effect synchronously (one edge).
- All registers update only on rising clk when key_valid=1, except res_valid. res_valid is 1 only in the cycle after an accepted EQUAL and is 0 otherwise.
- Digit shift: reg <= {reg[WIDTH-DIGIT_W-1:0], digit}, upper bits discarded (modulo 2^WIDTH). For WIDTH=6: reg <= {reg[1:0], d}.
- States (2-bit encoding): ENTER_A=0, ENTER_B=1, SHOW=2; 3 is illegal and recovers to ENTER_A on the next edge.
- ENTER_A:
  - digit: shift into a; disp <= new a.
  - PLUS/MINUS: sub_sel <= 0/1; b <= 0; go to ENTER_B.
  - EQUAL: disp <= a; res_valid pulse; stay.
- ENTER_B:
  - digit: shift into b; disp <= new b.
  - PLUS/MINUS: replace sub_sel only; b unchanged.
  - EQUAL: disp <= result; a <= result; res_valid pulse; go to SHOW.
- SHOW:
  - digit: a <= {0, digit}; b <= 0; disp <= new a; go to ENTER_A (fresh calculation).
  - PLUS/MINUS: a keeps the prior result; b <= 0; set sub_sel; go to ENTER_B (chaining).
  - EQUAL: repeat the last operation, i.e. disp <= result; a <= result; res_valid pulse; stay.
- result is sampled on the same edge that accepts EQUAL, so it reflects a/b/sub_sel from before that edge. No extra latency.
- Arithmetic wraps modulo 2^WIDTH; no overflow/borrow flag.
- Codes 20-31 are no-ops. key_valid=0 holds all state.
- key_valid held high for N cycles is N key events; debouncing is done upstream.

Decomposition:
- Package calc_pkg: KEY_PLUS=16, KEY_MINUS=17, KEY_EQUAL=18, KEY_CLEAR=19, state encodings ST_ENTER_A/ST_ENTER_B/ST_SHOW, WIDTH default.
- One natural sub-module: calc_operand_reg. It is a WIDTH-bit register with clear, load and shift-in-digit controls, instantiated twice (a, b).
- The FSM and the disp/res_valid logic stay in calc_key_seq.
- Bench instantiates calc_key_seq together with the existing add/sub unit (result fed back).

Test Plan:
- Keys 2,+,3,= -> a=6'h02, b=6'h03, sub_sel=0; disp=6'h05; res_valid high exactly one cycle after '='; state=SHOW.
- Keys 4,-,7,= -> sub_sel=1, disp=6'h3d (wrap); a=6'h3d afterwards.
- Digit overflow: keys 1,f -> a=6'h1f; then 3 -> a=6'h33 (only low 2 bits of 6'h1f kept).
- Chaining: after disp=6'h05, keys -,1,= -> disp=6'h04; '=' again -> disp=6'h03, second res_valid pulse; then digit 9 -> a=6'h09, b=0, state=ENTER_A.
- Operator change: keys 6,+,-,3,= -> disp=6'h03 (MINUS wins). key_code 25 mid-entry -> no register change.
- rst pulsed asynchronously between clk edges during ENTER_B with b=6'h0e -> all outputs 0 immediately, state=ENTER_A. CLEAR key in SHOW -> same values after one edge.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared constants for the calc key-entry front end: key codes,
//            sequencer state encodings and default datapath widths.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Default datapath geometry; WIDTH must match the add/sub unit.
    localparam int CALC_WIDTH   = 6;
    localparam int CALC_DIGIT_W = 4;
    localparam int KEY_W        = 5;

    // Key codes above the hex digits (0-15). Codes 20-31 are ignored.
    localparam logic [KEY_W-1:0] KEY_PLUS  = 5'd16;
    localparam logic [KEY_W-1:0] KEY_MINUS = 5'd17;
    localparam logic [KEY_W-1:0] KEY_EQUAL = 5'd18;
    localparam logic [KEY_W-1:0] KEY_CLEAR = 5'd19;

    // Sequencer states. Encoding 2'd3 is unused and recovers to ENTER_A.
    localparam logic [1:0] ST_ENTER_A = 2'd0;
    localparam logic [1:0] ST_ENTER_B = 2'd1;
    localparam logic [1:0] ST_SHOW    = 2'd2;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_operand_reg.sv
`default_nettype none
// ============================================================================
// Module   : calc_operand_reg
// Purpose  : WIDTH-bit operand register with clear, parallel load and
//            hex-digit shift-in. Priority: clr > load > shift > hold.
// Ports    : clk, rst      - clock, async active-high reset
//            clr           - synchronous clear to zero
//            load/load_val - parallel load
//            shift/digit   - q <= {q[WIDTH-DIGIT_W-1:0], digit}
//            q             - register contents
// Revision : 1.0 - initial release
// ============================================================================
module calc_operand_reg
    import calc_pkg::*;
#(
    parameter int WIDTH   = CALC_WIDTH,
    parameter int DIGIT_W = CALC_DIGIT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               shift,
    input  logic [DIGIT_W-1:0] digit,
    output logic [WIDTH-1:0]   q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= load_val;
        end else if (shift) begin
            // Upper bits fall off the top: entry wraps modulo 2^WIDTH.
            r_q <= {r_q[WIDTH-DIGIT_W-1:0], digit};
        end
    end

    assign q = r_q;

endmodule : calc_operand_reg
`default_nettype wire

// File: rtl/calc_key_seq.sv
`default_nettype none
// ============================================================================
// Module   : calc_key_seq
// Purpose  : Operand-entry sequencer feeding the add/sub unit. Builds A and B
//            from hex key presses, selects add/sub, latches the unit's
//            combinational result on '=' and supports chained operations.
// Ports    : clk, rst            - clock, async active-high reset
//            key_valid, key_code - one key event per cycle with key_valid=1
//            result              - add/sub unit output (a op b)
//            a, b, sub_sel       - operands/operation to the add/sub unit
//            disp                - value for the display stage
//            res_valid           - one-cycle pulse after an accepted '='
//            state               - current sequencer state (debug/LEDs)
// Revision : 1.0 - initial release
// ============================================================================
module calc_key_seq
    import calc_pkg::*;
#(
    parameter int WIDTH   = CALC_WIDTH,
    parameter int DIGIT_W = CALC_DIGIT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_code,
    input  logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             sub_sel,
    output logic [WIDTH-1:0] disp,
    output logic             res_valid,
    output logic [1:0]       state
);

    localparam logic [KEY_W-1:0] c_digit_lim = KEY_W'(2 ** DIGIT_W);

    logic [1:0]       r_state;
    logic             r_sub_sel;
    logic [WIDTH-1:0] r_disp;
    logic             r_res_valid;

    logic [1:0]         w_state_nxt;
    logic               w_sub_nxt;
    logic [WIDTH-1:0]   w_disp_nxt;
    logic               w_res_valid_nxt;
    logic               w_a_clr, w_a_load, w_a_shift;
    logic               w_b_clr, w_b_shift;
    logic [WIDTH-1:0]   w_a_load_val;

    // Key decode
    logic               w_is_digit, w_is_op, w_is_equal, w_is_clear;
    logic [DIGIT_W-1:0] w_digit;
    logic [WIDTH-1:0]   w_digit_ext;
    logic [WIDTH-1:0]   w_a_shifted, w_b_shifted;

    assign w_is_digit  = (key_code < c_digit_lim);
    assign w_is_op     = (key_code == KEY_PLUS) || (key_code == KEY_MINUS);
    assign w_is_equal  = (key_code == KEY_EQUAL);
    assign w_is_clear  = (key_code == KEY_CLEAR);
    assign w_digit     = key_code[DIGIT_W-1:0];
    assign w_digit_ext = {{(WIDTH-DIGIT_W){1'b0}}, w_digit};

    // Post-shift operand values, so disp can show the new operand in the
    // same edge that shifts it in.
    assign w_a_shifted = {a[WIDTH-DIGIT_W-1:0], w_digit};
    assign w_b_shifted = {b[WIDTH-DIGIT_W-1:0], w_digit};

    always_comb begin
        w_state_nxt     = r_state;
        w_sub_nxt       = r_sub_sel;
        w_disp_nxt      = r_disp;
        w_res_valid_nxt = 1'b0;
        w_a_clr         = 1'b0;
        w_a_load        = 1'b0;
        w_a_shift       = 1'b0;
        w_a_load_val    = result;
        w_b_clr         = 1'b0;
        w_b_shift       = 1'b0;

        case (r_state)
            ST_ENTER_A: begin
                if (key_valid) begin
                    if (w_is_digit) begin
                        w_a_shift  = 1'b1;
                        w_disp_nxt = w_a_shifted;
                    end else if (w_is_op) begin
                        w_sub_nxt   = (key_code == KEY_MINUS);
                        w_b_clr     = 1'b1;
                        w_state_nxt = ST_ENTER_B;
                    end else if (w_is_equal) begin
                        w_disp_nxt      = a;
                        w_res_valid_nxt = 1'b1;
                    end
                end
            end
            ST_ENTER_B: begin
                if (key_valid) begin
                    if (w_is_digit) begin
                        w_b_shift  = 1'b1;
                        w_disp_nxt = w_b_shifted;
                    end else if (w_is_op) begin
                        // Later operator key overrides the earlier one.
                        w_sub_nxt = (key_code == KEY_MINUS);
                    end else if (w_is_equal) begin
                        w_a_load        = 1'b1;
                        w_disp_nxt      = result;
                        w_res_valid_nxt = 1'b1;
                        w_state_nxt     = ST_SHOW;
                    end
                end
            end
            ST_SHOW: begin
                if (key_valid) begin
                    if (w_is_digit) begin
                        // Fresh calculation: digit starts a new A.
                        w_a_load     = 1'b1;
                        w_a_load_val = w_digit_ext;
                        w_b_clr      = 1'b1;
                        w_disp_nxt   = w_digit_ext;
                        w_state_nxt  = ST_ENTER_A;
                    end else if (w_is_op) begin
                        // Chaining: prior result already sits in A.
                        w_sub_nxt   = (key_code == KEY_MINUS);
                        w_b_clr     = 1'b1;
                        w_state_nxt = ST_ENTER_B;
                    end else if (w_is_equal) begin
                        // Repeat last operation with B and sub_sel kept.
                        w_a_load        = 1'b1;
                        w_disp_nxt      = result;
                        w_res_valid_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_ENTER_A;
            end
        endcase

        // CLEAR behaves as a synchronous reset from any state.
        if (key_valid && w_is_clear) begin
            w_state_nxt     = ST_ENTER_A;
            w_sub_nxt       = 1'b0;
            w_disp_nxt      = '0;
            w_res_valid_nxt = 1'b0;
            w_a_clr         = 1'b1;
            w_a_load        = 1'b0;
            w_a_shift       = 1'b0;
            w_b_clr         = 1'b1;
            w_b_shift       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ENTER_A;
            r_sub_sel   <= 1'b0;
            r_disp      <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sub_sel   <= w_sub_nxt;
            r_disp      <= w_disp_nxt;
            r_res_valid <= w_res_valid_nxt;
        end
    end

    calc_operand_reg #(
        .WIDTH   (WIDTH),
        .DIGIT_W (DIGIT_W)
    ) u_a_reg (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_a_clr),
        .load     (w_a_load),
        .load_val (w_a_load_val),
        .shift    (w_a_shift),
        .digit    (w_digit),
        .q        (a)
    );

    calc_operand_reg #(
        .WIDTH   (WIDTH),
        .DIGIT_W (DIGIT_W)
    ) u_b_reg (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_b_clr),
        .load     (1'b0),
        .load_val ({WIDTH{1'b0}}),
        .shift    (w_b_shift),
        .digit    (w_digit),
        .q        (b)
    );

    assign sub_sel   = r_sub_sel;
    assign disp      = r_disp;
    assign res_valid = r_res_valid;
    assign state     = r_state;

endmodule : calc_key_seq
`default_nettype wire

// File: tb/tb_calc_key_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_key_seq
// Purpose  : Self-checking bench for calc_key_seq with a behavioural add/sub
//            unit in the feedback path. Expected '=' results are queued at
//            stimulus time and popped by a monitor on each res_valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_key_seq;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic [4:0]   key_code = 5'd0;
    logic [W-1:0] result;
    logic [W-1:0] a, b, disp;
    logic         sub_sel, res_valid;
    logic [1:0]   state;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    // Add/sub unit stand-in: combinational, wraps modulo 2^W.
    assign result = sub_sel ? (a - b) : (a + b);

    calc_key_seq #(.WIDTH(W), .DIGIT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .result    (result),
        .a         (a),
        .b         (b),
        .sub_sel   (sub_sel),
        .disp      (disp),
        .res_valid (res_valid),
        .state     (state)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; drives one key for one edge.
    task automatic press(input logic [4:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 5'd0;
    endtask

    task automatic press_eq(input logic [W-1:0] exp_disp);
        exp_q.push_back(exp_disp);
        press(5'd18);
    endtask

    // Monitor: every res_valid cycle must match the next queued result.
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res_valid_unexpected: got disp=%h with no result pending", disp);
            end else begin
                check("disp_on_res_valid", disp, exp_q.pop_front());
            end
        end
    end

    initial begin
        #12;
        check("rst_a", a, 6'h00);
        check("rst_b", b, 6'h00);
        check("rst_sub", {5'd0, sub_sel}, 6'h00);
        check("rst_disp", disp, 6'h00);
        check("rst_rv", {5'd0, res_valid}, 6'h00);
        check("rst_state", {4'd0, state}, 6'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // '=' in ENTER_A shows A and stays.
        press(5'd5);
        press_eq(6'h05);
        check("eqA_state", {4'd0, state}, 6'h00);
        press(5'd19);

        // 2 + 3 =
        press(5'd2);
        press(5'd16);
        press(5'd3);
        check("add_a", a, 6'h02);
        check("add_b", b, 6'h03);
        check("add_sub", {5'd0, sub_sel}, 6'h00);
        press_eq(6'h05);
        check("add_state", {4'd0, state}, 6'h02);

        // Chaining: - 1 = then = again, then fresh digit.
        press(5'd17);
        check("chain_b0", b, 6'h00);
        check("chain_state", {4'd0, state}, 6'h01);
        press(5'd1);
        press_eq(6'h04);
        press_eq(6'h03);
        check("repeat_a", a, 6'h03);
        press(5'd9);
        check("fresh_a", a, 6'h09);
        check("fresh_b", b, 6'h00);
        check("fresh_state", {4'd0, state}, 6'h00);
        check("fresh_disp", disp, 6'h09);

        // 4 - 7 = wraps to 0x3d.
        press(5'd19);
        press(5'd4);
        press(5'd17);
        press(5'd7);
        check("sub_sel", {5'd0, sub_sel}, 6'h01);
        press_eq(6'h3d);
        check("wrap_a", a, 6'h3d);

        // Digit overflow.
        press(5'd19);
        press(5'd1);
        press(5'd15);
        check("ovf_a1", a, 6'h1f);
        press(5'd3);
        check("ovf_a2", a, 6'h33);
        check("ovf_disp", disp, 6'h33);

        // Operator change and ignored code.
        press(5'd19);
        press(5'd6);
        press(5'd16);
        press(5'd17);
        press(5'd3);
        press(5'd25);
        check("ign_a", a, 6'h06);
        check("ign_b", b, 6'h03);
        check("ign_sub", {5'd0, sub_sel}, 6'h01);
        check("ign_state", {4'd0, state}, 6'h01);
        check("ign_disp", disp, 6'h03);
        press_eq(6'h03);

        // CLEAR in SHOW.
        check("show_state", {4'd0, state}, 6'h02);
        press(5'd19);
        check("clr_a", a, 6'h00);
        check("clr_b", b, 6'h00);
        check("clr_disp", disp, 6'h00);
        check("clr_sub", {5'd0, sub_sel}, 6'h00);
        check("clr_state", {4'd0, state}, 6'h00);

        // Async reset mid-entry in ENTER_B with b=0x0e.
        press(5'd14);
        press(5'd16);
        press(5'd14);
        check("pre_rst_b", b, 6'h0e);
        #2;
        rst = 1'b1;
        #1;
        check("arst_a", a, 6'h00);
        check("arst_b", b, 6'h00);
        check("arst_disp", disp, 6'h00);
        check("arst_rv", {5'd0, res_valid}, 6'h00);
        check("arst_state", {4'd0, state}, 6'h00);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        repeat (3) @(posedge clk);
        #1;
        check("pending_results", W'(exp_q.size()), 6'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_calc_key_seq
`default_nettype wire
